// File: rtl/sccb_target_if.sv
// SCCB target bus bundle: pad-level SIOC/SIOD plus the
// register-bank side (write strobe, pointer, read data).
interface sccb_target_if;
  logic       sioc;
  logic       siod_in;
  logic       siod_oe;
  logic       busy;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport slave (
    input  sioc, siod_in, rd_data,
    output siod_oe, busy, wr_en, wr_addr, wr_data, rd_addr
  );

  modport master (
    output sioc, siod_in, rd_data,
    input  siod_oe, busy, wr_en, wr_addr, wr_data, rd_addr
  );
endinterface

// File: rtl/sccb_target.sv
// Oversampled SCCB target: decodes ID/SUB/DATA writes into a
// register-write strobe and serves reads from a pointer.
module sccb_target #(
  parameter logic [7:0] SID = 8'h42
) (
  input logic        clk,
  input logic        rst,
  sccb_target_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [6:0] tx_q, tx_d;
  logic       rmode_q, rmode_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] ptr_q, ptr_d;

  logic c_s1, c_s2, c_q;
  logic d_s1, d_s2, d_q;

  // Idle bus level is high, so sync stages reset high
  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1 <= 1'b1; c_s2 <= 1'b1; c_q <= 1'b1;
      d_s1 <= 1'b1; d_s2 <= 1'b1; d_q <= 1'b1;
    end else begin
      c_s1 <= bus.sioc;    c_s2 <= c_s1; c_q <= c_s2;
      d_s1 <= bus.siod_in; d_s2 <= d_s1; d_q <= d_s2;
    end
  end

  logic rise, fall, start, stop;
  logic [7:0] byte_in;

  assign rise    = c_s2 & ~c_q;
  assign fall    = ~c_s2 & c_q;
  assign start   = c_q & d_q & ~d_s2;
  assign stop    = c_q & ~d_q & d_s2;
  assign byte_in = {sh_q, d_s2};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      rmode_q   <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      rmode_q   <= rmode_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    rmode_d   = rmode_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (start) begin
      state_d = ID;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ID, SUB, WDATA: begin
          if (rise) begin
            sh_d  = byte_in[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd8;
              unique case (state_q)
                ID: begin
                  if (byte_in == SID) begin
                    rmode_d = 1'b0;
                    state_d = ID_ACK;
                  end else if (byte_in == (SID | 8'h01)) begin
                    rmode_d = 1'b1;
                    state_d = ID_ACK;
                  end else begin
                    state_d = IGNORE;
                  end
                end
                SUB: begin
                  ptr_d   = byte_in;
                  state_d = SUB_ACK;
                end
                default: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = byte_in;
                  ptr_d     = ptr_q + 8'd1;
                  state_d   = WDATA_ACK;
                end
              endcase
            end
          end
        end
        // cnt 8: ack slot not yet opened; cnt 0: ack bit sampled
        ID_ACK, SUB_ACK, WDATA_ACK: begin
          if (rise) begin
            cnt_d = '0;
          end else if (fall) begin
            if (cnt_q == 4'd8) begin
              oe_d = 1'b1;
            end else if (state_q == ID_ACK && rmode_q) begin
              tx_d    = bus.rd_data[6:0];
              oe_d    = ~bus.rd_data[7];
              state_d = RDATA;
            end else begin
              oe_d    = 1'b0;
              state_d = (state_q == ID_ACK) ? SUB : WDATA;
            end
          end
        end
        RDATA: begin
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = RDATA_NA;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        RDATA_NA: begin
          if (rise) begin
            if (d_s2) begin
              state_d = IGNORE;
            end else begin
              cnt_d = '0;
              ptr_d = ptr_q + 8'd1;
            end
          end else if (fall && cnt_q == 4'd0) begin
            tx_d    = bus.rd_data[6:0];
            oe_d    = ~bus.rd_data[7];
            state_d = RDATA;
          end
        end
        IDLE, IGNORE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.siod_oe = oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_addr = ptr_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB master, register bank
// model and a scoreboard for write strobes and read bytes.
module tb_sccb_target;

  localparam logic [7:0] SID = 8'h42;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic scl_m, sda_m;

  always #5 clk = ~clk;

  sccb_target_if bus();

  sccb_target #(.SID(SID)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a * 8'd37) ^ 8'h5C;
  endfunction

  logic [7:0] hw_regs [256];
  logic       hw_wr   [256];

  assign bus.sioc    = scl_m;
  assign bus.siod_in = sda_m & ~bus.siod_oe;
  assign bus.rd_data = hw_wr[bus.rd_addr] ? hw_regs[bus.rd_addr]
                                          : init_val(bus.rd_addr);

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) hw_wr[i] <= 1'b0;
    end else if (bus.wr_en) begin
      hw_regs[bus.wr_addr] <= bus.wr_data;
      hw_wr[bus.wr_addr]   <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model
  logic [7:0] m_regs [256];
  logic [7:0] m_ptr;
  logic [7:0] wbuf [4];

  // Scoreboard queues
  logic [15:0] wq[$];
  logic [7:0]  rexp_q[$];
  logic [7:0]  robs_q[$];
  int          oe_rises = 0;
  logic        oe_prev  = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, expected no strobe",
                 bus.wr_addr, bus.wr_data);
      end else begin
        logic [15:0] e;
        e = wq.pop_front();
        check("wr_addr", bus.wr_addr, e[15:8]);
        check("wr_data", bus.wr_data, e[7:0]);
      end
    end
    if (robs_q.size() > 0 && rexp_q.size() > 0)
      check("rd_byte", robs_q.pop_front(), rexp_q.pop_front());
    if (bus.siod_oe && !oe_prev) oe_rises++;
    oe_prev = bus.siod_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, output logic seen);
    tick(5); sda_m = b;
    tick(5); scl_m = 1'b1;
    tick(5); seen = bus.siod_in;
    tick(5); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic na, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(na, s);
  endtask

  task automatic start_c();
    if (scl_m) begin
      tick(5);
    end else begin
      tick(5); sda_m = 1'b1;
      tick(5); scl_m = 1'b1;
      tick(10);
    end
    sda_m = 1'b0;
    tick(10);
    check("busy_start", bus.busy, 1);
    scl_m = 1'b0;
  endtask

  task automatic stop_c();
    tick(5); sda_m = 1'b0;
    tick(5); scl_m = 1'b1;
    tick(10); sda_m = 1'b1;
    tick(10);
  endtask

  task automatic write_txn(input logic [7:0] id, input logic [7:0] sub,
                           input int n, input bit abort4);
    bit   adr;
    int   base;
    logic a, s;
    adr  = (id == SID);
    base = oe_rises;
    start_c();
    send_byte(id, a);
    check("ack_id", a, adr ? 0 : 1);
    send_byte(sub, a);
    check("ack_sub", a, adr ? 0 : 1);
    if (adr) m_ptr = sub;
    for (int i = 0; i < n; i++) begin
      if (adr) begin
        wq.push_back({m_ptr, wbuf[i]});
        m_regs[m_ptr] = wbuf[i];
        m_ptr = m_ptr + 8'd1;
      end
      send_byte(wbuf[i], a);
      check("ack_data", a, adr ? 0 : 1);
    end
    if (abort4)
      for (int k = 0; k < 4; k++) bit_cycle(k[0], s);
    stop_c();
    check("busy_stop", bus.busy, 0);
    check("oe_idle", bus.siod_oe, 0);
    check("rd_addr", bus.rd_addr, m_ptr);
    check("ack_slots", oe_rises - base, adr ? 2 + n : 0);
  endtask

  task automatic read_txn(input logic [7:0] sub, input int n, input bit rs);
    logic       a;
    logic [7:0] d;
    start_c();
    send_byte(SID, a);
    check("ack_id", a, 0);
    send_byte(sub, a);
    check("ack_sub", a, 0);
    m_ptr = sub;
    if (!rs) stop_c();
    start_c();
    send_byte(SID | 8'h01, a);
    check("ack_rid", a, 0);
    for (int i = 0; i < n; i++) begin
      rexp_q.push_back(m_regs[m_ptr]);
      recv_byte(i == n - 1, d);
      robs_q.push_back(d);
      if (i < n - 1) m_ptr = m_ptr + 8'd1;
    end
    stop_c();
    check("busy_stop", bus.busy, 0);
    check("oe_idle", bus.siod_oe, 0);
    check("rd_addr", bus.rd_addr, m_ptr);
  endtask

  initial begin
    logic       a, s;
    logic [7:0] id;
    int         base;
    rst   = 1'b1;
    clr   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    m_ptr = 8'h00;
    for (int i = 0; i < 256; i++) m_regs[i] = init_val(8'(i));
    tick(4);
    check("rst_oe", bus.siod_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    rst = 1'b0;
    clr = 1'b0;
    tick(5);

    // 3-phase write
    wbuf[0] = 8'h80;
    write_txn(SID, 8'h12, 1, 1'b0);
    // wrong ID with two bytes
    wbuf[0] = 8'h55;
    write_txn(8'h60, 8'h33, 1, 1'b0);
    // place 0x76 at 0x0A, then 2-phase write + read
    wbuf[0] = 8'h76;
    write_txn(SID, 8'h0A, 1, 1'b0);
    read_txn(8'h0A, 1, 1'b0);
    // multi-byte write wrapping the pointer
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    write_txn(SID, 8'hFF, 2, 1'b0);
    // data byte cut short by STOP, then a normal write
    write_txn(SID, 8'h20, 0, 1'b1);
    wbuf[0] = 8'h33;
    write_txn(SID, 8'h05, 1, 1'b0);
    // multi-byte read with repeated start
    read_txn(8'hFE, 3, 1'b1);

    // reset while the target drives a read bit
    start_c();
    send_byte(SID, a);
    send_byte(8'h0A, a);
    stop_c();
    start_c();
    send_byte(SID | 8'h01, a);
    check("ack_rid", a, 0);
    tick(6);
    check("oe_read_bit", bus.siod_oe, 1);
    base = oe_rises;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_ptr = 8'h00;
    check("rst_mid_oe", bus.siod_oe, 0);
    check("rst_mid_rd_addr", bus.rd_addr, 0);
    check("rst_mid_busy", bus.busy, 0);
    tick(3); scl_m = 1'b1;
    tick(10); scl_m = 1'b0;
    for (int i = 0; i < 8; i++) bit_cycle(1'b1, s);
    check("rst_ignored_oe", oe_rises - base, 0);
    check("rst_ignored_busy", bus.busy, 0);
    stop_c();
    check("rst_after_stop_rd", bus.rd_addr, 0);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      int kind;
      int n;
      kind = $urandom_range(0, 2);
      n    = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      if (kind == 0) begin
        write_txn(SID, 8'($urandom), n, 1'b0);
      end else if (kind == 1) begin
        id = 8'($urandom);
        if (id[7:1] == SID[7:1]) id = id ^ 8'h80;
        write_txn(id, 8'($urandom), n, 1'b0);
      end else begin
        read_txn(8'($urandom), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end
    end

    tick(20);
    check("wr_queue_drained", wq.size(), 0);
    check("rd_queue_drained", rexp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
